// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - MM:SS.cc stopwatch with start/stop, lap freeze and clear
module stopwatch_ctrl #(
    parameter int TICK_DIV = 500000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iSTART_STOP,
    input  logic       iLAP,
    input  logic       iCLEAR,
    output logic [3:0] oDIG0,
    output logic [3:0] oDIG1,
    output logic [3:0] oDIG2,
    output logic [3:0] oDIG3,
    output logic [3:0] oDIG4,
    output logic [3:0] oDIG5,
    output logic       oRUN,
    output logic       oLAP
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_LAP  = 2'd3
    } state_t;

    // Button bit order: [2] clear, [1] start/stop, [0] lap
    logic [2:0]    btn_now;
    logic [2:0]    btn_prev_q, btn_prev_d;
    logic [2:0]    btn_arm_q, btn_arm_d;
    logic [2:0]    btn_ev;
    logic          ev_clr, ev_ss, ev_lap;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [23:0]   cnt_q, cnt_d;
    logic [23:0]   lap_q, lap_d;
    logic [23:0]   disp_q, disp_d;
    logic          run_q, run_d;
    logic          lapo_q, lapo_d;

    logic          counting;
    logic          tick;
    logic          clear_go;

    // Time layout, low to high nibble: cs ones, cs tens, s ones, s tens, m ones, m tens.
    // Seconds tens and minutes tens roll over after 5, the rest after 9.
    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  lim;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (v[4*i +: 4] == lim) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Rising-edge events; a button must be seen low after reset before it can fire,
    // so one held through reset release stays silent until re-pressed.
    always_comb begin
        btn_now   = {iCLEAR, iSTART_STOP, iLAP};
        btn_ev    = btn_now & ~btn_prev_q & btn_arm_q;
        btn_prev_d = btn_now;
        btn_arm_d = btn_arm_q | ~btn_now;
        ev_clr    = btn_ev[2];
        ev_ss     = btn_ev[1];
        ev_lap    = btn_ev[0];
    end

    // Next state: clear beats start/stop beats lap, invalid events fall through
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ev_ss) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ev_ss)       state_d = ST_STOP;
                else if (ev_lap) state_d = ST_LAP;
            end
            ST_STOP: begin
                if (ev_clr)     state_d = ST_IDLE;
                else if (ev_ss) state_d = ST_RUN;
            end
            ST_LAP: begin
                if (ev_ss)       state_d = ST_STOP;
                else if (ev_lap) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Prescaler, BCD time, lap capture and registered display sources.
    // Counting follows the state held during the edge, so a tick landing on
    // the edge that leaves RUN/LAP still counts, and lap capture takes the
    // pre-increment value.
    always_comb begin
        counting = (state_q == ST_RUN) || (state_q == ST_LAP);
        tick     = counting && (pre_q == PRE_MAX);
        clear_go = (state_q == ST_STOP) && ev_clr;

        pre_d = pre_q;
        cnt_d = cnt_q;
        lap_d = lap_q;

        if (counting) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end
        if (tick) begin
            cnt_d = bcd_inc(cnt_q);
        end
        if (state_q == ST_RUN && state_d == ST_LAP) begin
            lap_d = cnt_q;
        end
        if (clear_go) begin
            pre_d = '0;
            cnt_d = '0;
            lap_d = '0;
        end

        disp_d = (state_q == ST_LAP) ? lap_q : cnt_q;
        run_d  = counting;
        lapo_d = (state_q == ST_LAP);
    end

    // All state registers; reset wins over any button activity
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            btn_prev_q <= '0;
            btn_arm_q  <= '0;
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            cnt_q      <= '0;
            lap_q      <= '0;
            disp_q     <= '0;
            run_q      <= 1'b0;
            lapo_q     <= 1'b0;
        end else begin
            btn_prev_q <= btn_prev_d;
            btn_arm_q  <= btn_arm_d;
            state_q    <= state_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            lap_q      <= lap_d;
            disp_q     <= disp_d;
            run_q      <= run_d;
            lapo_q     <= lapo_d;
        end
    end

    assign oDIG0 = disp_q[3:0];
    assign oDIG1 = disp_q[7:4];
    assign oDIG2 = disp_q[11:8];
    assign oDIG3 = disp_q[15:12];
    assign oDIG4 = disp_q[19:16];
    assign oDIG5 = disp_q[23:20];
    assign oRUN  = run_q;
    assign oLAP  = lapo_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - stopwatch_ctrl bench: vector table, corner sequences, random vs model
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int FULL = 360000;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;
    localparam int M_LAP  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss, lp, clr;
    logic [3:0] d0, d1, d2, d3, d4, d5;
    logic       orun, olap;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    bit preload = 1'b0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICK_DIV(TD)) dut (
        .iCLK(clk), .iRST(rst), .iSTART_STOP(ss), .iLAP(lp), .iCLEAR(clr),
        .oDIG0(d0), .oDIG1(d1), .oDIG2(d2), .oDIG3(d3), .oDIG4(d4), .oDIG5(d5),
        .oRUN(orun), .oLAP(olap)
    );

    // Reference model: time kept as plain centiseconds since 00:00.00
    int m_mode, m_cs, m_lap, m_pre, m_disp;
    bit m_run, m_olap;
    bit m_prev [3];
    bit m_seen_low [3];

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic model_step();
        bit in_b [3];
        bit ev [3];
        bit counting;
        bit tick;
        int nxt;
        in_b[0] = ss; in_b[1] = lp; in_b[2] = clr;
        if (rst) begin
            m_mode = M_IDLE; m_cs = 0; m_lap = 0; m_pre = 0; m_disp = 0;
            m_run = 0; m_olap = 0;
            for (int i = 0; i < 3; i++) begin
                m_prev[i] = 0;
                m_seen_low[i] = 0;
            end
            return;
        end
        if (preload) m_cs = FULL - 1;
        m_disp = (m_mode == M_LAP) ? m_lap : m_cs;
        m_run  = (m_mode == M_RUN) || (m_mode == M_LAP);
        m_olap = (m_mode == M_LAP);
        for (int i = 0; i < 3; i++) begin
            ev[i] = in_b[i] && !m_prev[i] && m_seen_low[i];
            m_prev[i] = in_b[i];
            if (!in_b[i]) m_seen_low[i] = 1;
        end
        counting = m_run;
        tick = counting && (m_pre == TD - 1);
        nxt = m_mode;
        if (ev[2] && m_mode == M_STOP)              nxt = M_IDLE;
        else if (ev[0])                             nxt = counting ? M_STOP : M_RUN;
        else if (ev[1] && m_mode == M_RUN)          nxt = M_LAP;
        else if (ev[1] && m_mode == M_LAP)          nxt = M_RUN;
        if (m_mode == M_RUN && nxt == M_LAP) m_lap = m_cs;
        if (counting) begin
            if (tick) m_cs = (m_cs + 1) % FULL;
            m_pre = (m_pre + 1) % TD;
        end
        if (m_mode == M_STOP && nxt == M_IDLE) begin
            m_cs = 0; m_pre = 0; m_lap = 0;
        end
        m_mode = nxt;
    endtask

    always @(posedge clk) model_step();

    task automatic model_cmp();
        logic [23:0] got, exp;
        got = {d5, d4, d3, d2, d1, d0};
        exp = to_bcd(m_disp);
        total++;
        if (got !== exp || orun !== m_run || olap !== m_olap) begin
            bad++;
            $display("FAIL model t=%0t got dig=%h run=%b lap=%b want dig=%h run=%b lap=%b",
                     $time, got, orun, olap, exp, m_run, m_olap);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (chk_en) model_cmp();
    endtask

    task automatic chk(input string nm, input int ecs, input bit er, input bit el);
        logic [23:0] got, exp;
        got = {d5, d4, d3, d2, d1, d0};
        exp = to_bcd(ecs);
        total++;
        if (got !== exp || orun !== er || olap !== el) begin
            bad++;
            $display("FAIL %s got dig=%h run=%b lap=%b want dig=%h run=%b lap=%b",
                     nm, got, orun, olap, exp, er, el);
        end
    endtask

    task automatic pulse(input bit s, input bit l, input bit c, input int w);
        ss = s; lp = l; clr = c;
        cyc();
        ss = 0; lp = 0; clr = 0;
        repeat (w) cyc();
    endtask

    task automatic do_reset();
        rst = 1; ss = 0; lp = 0; clr = 0;
        cyc();
        cyc();
        rst = 0;
        cyc();
    endtask

    typedef struct {
        bit s;
        bit l;
        bit c;
        int n_wait;
        int e_cs;
        bit e_run;
        bit e_lap;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1, 0, 0, 402,  100, 1, 0};
        tbl[1]  = '{0, 0, 1, 7,    102, 1, 0};
        tbl[2]  = '{1, 0, 0, 1000, 102, 0, 0};
        tbl[3]  = '{1, 0, 0, 6,    104, 1, 0};
        tbl[4]  = '{0, 1, 0, 40,   104, 1, 1};
        tbl[5]  = '{0, 1, 0, 2,    115, 1, 0};
        tbl[6]  = '{1, 1, 0, 3,    115, 0, 0};
        tbl[7]  = '{1, 0, 1, 2,    0,   0, 0};
        tbl[8]  = '{0, 1, 0, 3,    0,   0, 0};
        tbl[9]  = '{0, 0, 1, 2,    0,   0, 0};
        tbl[10] = '{1, 0, 0, 10,   2,   1, 0};

        rst = 1; ss = 0; lp = 0; clr = 0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("reset", 0, 0, 0);
        rst = 0;
        cyc();

        for (int i = 0; i < 11; i++) begin
            pulse(tbl[i].s, tbl[i].l, tbl[i].c, tbl[i].n_wait);
            chk($sformatf("vec%0d", i), tbl[i].e_cs, tbl[i].e_run, tbl[i].e_lap);
        end

        // Lap freeze at 00:00.05 across 20 ticks, then release to live 00:00.25
        do_reset();
        pulse(1, 0, 0, 20);
        pulse(0, 1, 0, 79);
        chk("lap_hold", 5, 1, 1);
        pulse(0, 1, 0, 1);
        chk("lap_release", 25, 1, 0);

        // Wrap from 59:59.99 to 00:00.00 while running
        do_reset();
        pulse(1, 0, 0, 8);
        preload = 1;
        force dut.cnt_q = 24'h595999;
        cyc();
        release dut.cnt_q;
        preload = 0;
        cyc();
        chk("preload", FULL - 1, 1, 0);
        repeat (3) cyc();
        chk("wrap", 0, 1, 0);
        repeat (4) cyc();
        chk("after_wrap", 1, 1, 0);

        // Reset in LAP with start/stop held across release
        do_reset();
        pulse(1, 0, 0, 2);
        pulse(0, 1, 0, 2);
        ss = 1; rst = 1;
        cyc();
        chk("rst_in_lap", 0, 0, 0);
        rst = 0;
        repeat (4) cyc();
        chk("held_no_start", 0, 0, 0);
        ss = 0;
        cyc();
        pulse(1, 0, 0, 3);
        chk("repress_start", 0, 1, 0);

        // Random buttons and occasional reset against the model
        for (int i = 0; i < 12000; i++) begin
            rst = ($urandom_range(0, 799) == 0);
            ss  = ($urandom_range(0, 11) == 0);
            lp  = ($urandom_range(0, 11) == 0);
            clr = ($urandom_range(0, 5) == 0);
            cyc();
        end
        rst = 0; ss = 0; lp = 0; clr = 0;
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
